// File: rtl/be_ram_pkg.sv
// Shared derivations and parameter legality rules for the byte-enabled RAM stream.
package be_ram_pkg;

    function automatic int unsigned columns(int unsigned dw, int unsigned cw);
        return (cw == 0) ? 0 : dw / cw;
    endfunction

    function automatic int unsigned rsp_depth(int unsigned oreg);
        return 2 + oreg;
    endfunction

    function automatic bit params_legal(int unsigned aw, int unsigned dw, int unsigned cw,
                                        int unsigned oreg, int unsigned row);
        return (aw != 0) && (cw != 0) && (dw >= cw) && ((dw % cw) == 0) &&
               (oreg <= 1) && (row <= 1);
    endfunction

endpackage

// File: rtl/be_ram_array.sv
// Single-port byte-enabled storage with read-first registered read.
module be_ram_array
    import be_ram_pkg::*;
#(
    parameter int unsigned ADDRESS_BITWIDTH = 16,
    parameter int unsigned DATA_BITWIDTH    = 32,
    parameter int unsigned COLUMN_BITWIDTH  = 8
) (
    input  logic                                               clk,
    input  logic                                               en,
    input  logic [columns(DATA_BITWIDTH, COLUMN_BITWIDTH)-1:0] we,
    input  logic [ADDRESS_BITWIDTH-1:0]                        addr,
    input  logic [DATA_BITWIDTH-1:0]                           wdata,
    output logic [DATA_BITWIDTH-1:0]                           rdata
);

    localparam int unsigned COLUMNS = columns(DATA_BITWIDTH, COLUMN_BITWIDTH);
    localparam int unsigned DEPTH   = 2 ** ADDRESS_BITWIDTH;

    logic [DATA_BITWIDTH-1:0] mem [DEPTH];

    // Read returns the word as it was before this edge's lane writes.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int c = 0; c < COLUMNS; c++) begin
                if (we[c]) begin
                    mem[addr][c*COLUMN_BITWIDTH +: COLUMN_BITWIDTH] <=
                        wdata[c*COLUMN_BITWIDTH +: COLUMN_BITWIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/be_ram_stream.sv
// Valid/ready request-response wrapper around be_ram_array with credit-based
// flow control and an in-order response FIFO.
module be_ram_stream
    import be_ram_pkg::*;
#(
    parameter int unsigned ADDRESS_BITWIDTH = 16,
    parameter int unsigned DATA_BITWIDTH    = 32,
    parameter int unsigned COLUMN_BITWIDTH  = 8,
    parameter int unsigned OUTPUT_REGISTER  = 0,
    parameter int unsigned RESPOND_ON_WRITE = 0
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               req_valid,
    output logic                                               req_ready,
    input  logic [ADDRESS_BITWIDTH-1:0]                        req_address,
    input  logic [columns(DATA_BITWIDTH, COLUMN_BITWIDTH)-1:0] req_write_enable,
    input  logic [DATA_BITWIDTH-1:0]                           req_data,
    output logic                                               rsp_valid,
    input  logic                                               rsp_ready,
    output logic [DATA_BITWIDTH-1:0]                           rsp_data
);

    localparam int unsigned RSP_DEPTH = rsp_depth(OUTPUT_REGISTER);
    localparam int unsigned CRED_W    = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W     = $clog2(RSP_DEPTH);

    if (!params_legal(ADDRESS_BITWIDTH, DATA_BITWIDTH, COLUMN_BITWIDTH,
                      OUTPUT_REGISTER, RESPOND_ON_WRITE)) begin : g_illegal
        $error("be_ram_stream: DATA_BITWIDTH must be a multiple of COLUMN_BITWIDTH and flags must be 0/1");
    end

    logic                     ready_en;
    logic [CRED_W-1:0]        credits;
    logic                     accept;
    logic                     responds;
    logic                     take_credit;
    logic                     retire;
    logic                     p0_valid;
    logic [DATA_BITWIDTH-1:0] ram_rdata;
    logic                     arr_valid;
    logic [DATA_BITWIDTH-1:0] arr_data;
    logic [DATA_BITWIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CRED_W-1:0]        count;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;

    function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits bound outstanding responses to the FIFO size, so no FIFO overflow check is needed.
    assign req_ready   = ready_en & ~rst & (credits != '0);
    assign accept      = req_valid & req_ready;
    assign responds    = (req_write_enable == '0) || (RESPOND_ON_WRITE != 0);
    assign take_credit = accept & responds;

    be_ram_array #(
        .ADDRESS_BITWIDTH (ADDRESS_BITWIDTH),
        .DATA_BITWIDTH    (DATA_BITWIDTH),
        .COLUMN_BITWIDTH  (COLUMN_BITWIDTH)
    ) u_array (
        .clk   (clk),
        .en    (accept),
        .we    (req_write_enable),
        .addr  (req_address),
        .wdata (req_data),
        .rdata (ram_rdata)
    );

    if (OUTPUT_REGISTER != 0) begin : g_oreg
        logic                     p1_valid;
        logic [DATA_BITWIDTH-1:0] p1_data;
        always_ff @(posedge clk) begin
            if (rst) p1_valid <= 1'b0;
            else     p1_valid <= p0_valid;
            p1_data <= ram_rdata;
        end
        assign arr_valid = p1_valid;
        assign arr_data  = p1_data;
    end else begin : g_noreg
        assign arr_valid = p0_valid;
        assign arr_data  = ram_rdata;
    end

    // An arriving word bypasses the FIFO only when nothing is queued and it retires at once.
    assign fifo_empty = (count == '0);
    assign rsp_valid  = ~fifo_empty | arr_valid;
    assign rsp_data   = fifo_empty ? arr_data : fifo_mem[rd_ptr];
    assign retire     = rsp_valid & rsp_ready;
    assign push       = arr_valid & ~(fifo_empty & retire);
    assign pop        = ~fifo_empty & retire;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= arr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en <= 1'b0;
            credits  <= CRED_W'(RSP_DEPTH);
            p0_valid <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            ready_en <= 1'b1;
            p0_valid <= take_credit;
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + CRED_W'(1);
            else if (pop && !push) count <= count - CRED_W'(1);
            if (take_credit && !retire)      credits <= credits - CRED_W'(1);
            else if (retire && !take_credit) credits <= credits + CRED_W'(1);
        end
    end

endmodule

// File: tb/tb_be_ram_stream.sv
// Bench for be_ram_stream: dut0 uses defaults, dut1 has OUTPUT_REGISTER=1 and RESPOND_ON_WRITE=1.
module tb_be_ram_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [15:0] req_address [2];
    logic [3:0]  req_we      [2];
    logic [31:0] req_data    [2];
    logic        rsp_valid   [2];
    logic        rsp_ready   [2];
    logic [31:0] rsp_data    [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    be_ram_stream #(.OUTPUT_REGISTER(0), .RESPOND_ON_WRITE(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_address(req_address[0]),
        .req_write_enable(req_we[0]), .req_data(req_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0])
    );

    be_ram_stream #(.OUTPUT_REGISTER(1), .RESPOND_ON_WRITE(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_address(req_address[1]),
        .req_write_enable(req_we[1]), .req_data(req_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: word memory plus per-DUT queue of expected responses.
    // For dut k, OUTPUT_REGISTER = k, RESPOND_ON_WRITE = k, response depth = 2 + k.
    typedef struct {
        logic [31:0] data;
        bit          known;
        int          acc;
    } exp_t;

    exp_t        q [2][$];
    logic [31:0] mdl [int unsigned];
    bit          prev_rst = 1'b1;
    bit          m_er, m_ev, m_known;
    logic [31:0] m_old, m_new;
    int unsigned m_key;
    exp_t        m_e;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_er = !rst && !prev_rst && (q[k].size() < 2 + k);
            check($sformatf("req_ready%0d", k), 32'(req_ready[k]), 32'(m_er));
            m_ev = (q[k].size() > 0) && (q[k][0].acc + k <= cyc);
            check($sformatf("rsp_valid%0d", k), 32'(rsp_valid[k]), 32'(m_ev));
            if (m_ev && rsp_valid[k] && q[k][0].known)
                check($sformatf("rsp_data%0d", k), rsp_data[k], q[k][0].data);
            if (rst) begin
                q[k].delete();
            end else begin
                if (rsp_valid[k] && rsp_ready[k] && q[k].size() > 0) void'(q[k].pop_front());
                if (req_valid[k] && req_ready[k]) begin
                    m_key   = (k << 16) | 32'(req_address[k]);
                    m_known = mdl.exists(m_key);
                    m_old   = m_known ? mdl[m_key] : 32'h0;
                    if (req_we[k] == 4'h0 || k == 1) begin
                        m_e.data  = m_old;
                        m_e.known = m_known;
                        m_e.acc   = cyc + 1;
                        q[k].push_back(m_e);
                    end
                    if (req_we[k] != 4'h0 && (m_known || req_we[k] == 4'hF)) begin
                        m_new = m_old;
                        for (int b = 0; b < 4; b++)
                            if (req_we[k][b]) m_new[8*b +: 8] = req_data[k][8*b +: 8];
                        mdl[m_key] = m_new;
                    end
                end
            end
        end
        prev_rst = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request on dut k and hold it until accepted; returns just after the accept edge.
    task automatic issue(input int k, input logic [3:0] we, input logic [15:0] a, input logic [31:0] d);
        int n;
        req_valid[k] = 1'b1; req_we[k] = we; req_address[k] = a; req_data[k] = d;
        n = 0;
        @(negedge clk);
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[k]) begin
            total++; bad++;
            $display("FAIL accept_timeout dut%0d: req_ready stuck at 0, required 1", k);
        end
        step();
        req_valid[k] = 1'b0;
    endtask

    // One transaction with exact response latency (1 + k) and rsp_ready held high.
    task automatic xact(input int k, input logic [3:0] we, input logic [15:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input bit has_exp, input string name);
        bit exp_v;
        rsp_ready[k] = 1'b1;
        issue(k, we, a, d);
        exp_v = (we == 4'h0) || (k == 1);
        if (k == 1) begin
            @(negedge clk);
            check({name, "_early"}, 32'(rsp_valid[k]), 32'h0);
            @(posedge clk);
        end
        @(negedge clk);
        check({name, "_valid"}, 32'(rsp_valid[k]), 32'(exp_v));
        if (exp_v && has_exp) check({name, "_data"}, rsp_data[k], exp);
        step();
    endtask

    typedef struct {
        logic [3:0]  we;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        bit          has_exp;
    } vec_t;

    vec_t vt [8];
    int   nv;
    bit   all_ready;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // exp is the read result, or the pre-write word for a write response.
        vt[0] = '{4'hF, 16'h0010, 32'hDEADBEEF, 32'h0,        1'b0};
        vt[1] = '{4'h0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b1};
        vt[2] = '{4'h1, 16'h0010, 32'h000000AA, 32'hDEADBEEF, 1'b1};
        vt[3] = '{4'h0, 16'h0010, 32'h0,        32'hDEADBEAA, 1'b1};
        vt[4] = '{4'hF, 16'h0020, 32'h12345678, 32'h0,        1'b0};
        vt[5] = '{4'hA, 16'h0020, 32'hAABBCCDD, 32'h12345678, 1'b1};
        vt[6] = '{4'h0, 16'h0020, 32'h0,        32'hAA34CC78, 1'b1};
        vt[7] = '{4'h0, 16'h0010, 32'h0,        32'hDEADBEAA, 1'b1};

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 4'h0; req_address[k] = 16'h0;
            req_data[k] = 32'h0; rsp_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_rsp_valid%0d", k), 32'(rsp_valid[k]), 32'h0);
            check($sformatf("reset_req_ready%0d", k), 32'(req_ready[k]), 32'h0);
        end
        step();
        rst = 1'b0;
        step();

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++)
                xact(k, vt[i].we, vt[i].addr, vt[i].data, vt[i].exp, vt[i].has_exp,
                     $sformatf("vec%0d_dut%0d", i, k));

        // Write response on dut1 carries the pre-write word two cycles after accept.
        xact(1, 4'hF, 16'h0010, 32'h11223344, 32'hDEADBEAA, 1'b1, "row_write_pre");
        xact(1, 4'h0, 16'h0010, 32'h0, 32'h11223344, 1'b1, "row_readback");

        // Backpressure: two reads fill the credits, the third waits for the first retire.
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1; req_we[0] = 4'h0; req_address[0] = 16'h0010;
        @(negedge clk); check("bp_ready1", 32'(req_ready[0]), 32'h1);
        step(); req_address[0] = 16'h0020;
        @(negedge clk); check("bp_ready2", 32'(req_ready[0]), 32'h1);
        step(); req_address[0] = 16'h0010;
        @(negedge clk); check("bp_ready3_blocked", 32'(req_ready[0]), 32'h0);
        check("bp_head_data", rsp_data[0], 32'hDEADBEAA);
        step();
        @(negedge clk); check("bp_hold_blocked", 32'(req_ready[0]), 32'h0);
        check("bp_hold_data", rsp_data[0], 32'hDEADBEAA);
        step(); rsp_ready[0] = 1'b1;
        @(negedge clk); check("bp_still_blocked", 32'(req_ready[0]), 32'h0);
        step();
        @(negedge clk); check("bp_ready_after_retire", 32'(req_ready[0]), 32'h1);
        check("bp_second_data", rsp_data[0], 32'hAA34CC78);
        step(); req_valid[0] = 1'b0;
        @(negedge clk); check("bp_third_data", rsp_data[0], 32'hDEADBEAA);
        step();
        step();

        // Sixteen back-to-back reads must stream one response per cycle.
        nv = 0; all_ready = 1'b1;
        req_valid[0] = 1'b1; req_we[0] = 4'h0;
        for (int i = 0; i < 16; i++) begin
            req_address[0] = (i % 2 == 1) ? 16'h0020 : 16'h0010;
            @(negedge clk);
            if (!req_ready[0]) all_ready = 1'b0;
            if (i > 0 && rsp_valid[0]) nv++;
            step();
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
        if (rsp_valid[0]) nv++;
        check("stream_ready_held", 32'(all_ready), 32'h1);
        check("stream_rsp_count", 32'(nv), 32'd16);
        step();

        // Reset with two reads outstanding; a write presented during reset must be ignored.
        rsp_ready[0] = 1'b0;
        issue(0, 4'h0, 16'h0010, 32'h0);
        issue(0, 4'h0, 16'h0020, 32'h0);
        rst = 1'b1;
        req_valid[0] = 1'b1; req_we[0] = 4'hF; req_address[0] = 16'h0010; req_data[0] = 32'h0;
        step();
        rst = 1'b0; req_valid[0] = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid[0]), 32'h0);
        check("rst_req_ready_low", 32'(req_ready[0]), 32'h0);
        step();
        @(negedge clk);
        check("rst_req_ready_up", 32'(req_ready[0]), 32'h1);
        rsp_ready[0] = 1'b1;
        nv = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid[0]) nv++;
        end
        check("rst_no_stale", 32'(nv), 32'h0);
        step();
        xact(0, 4'h0, 16'h0010, 32'h0, 32'hDEADBEAA, 1'b1, "rst_mem_kept");

        // Randomized traffic over a pre-initialized window, checked by the model.
        for (int a = 0; a < 16; a++)
            for (int k = 0; k < 2; k++)
                issue(k, 4'hF, 16'h0100 + 16'(a), $urandom);
        repeat (600) begin
            for (int k = 0; k < 2; k++) begin
                req_valid[k]   = ($urandom_range(0, 9) < 7);
                req_we[k]      = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                req_address[k] = 16'h0100 + 16'($urandom_range(0, 15));
                req_data[k]    = $urandom;
                rsp_ready[k]   = ($urandom_range(0, 9) < 6);
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            rsp_ready[k] = 1'b1;
        end
        repeat (10) step();
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            check($sformatf("drain_empty%0d", k), 32'(q[k].size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
